// File: rtl/nrzi_destuff_decoder.sv
// NRZI receive decoder with bit destuffing and a small output FIFO toward the framer.
// Optional: define NRZI_DESTUFF_STUFF_ERROR_EN to flag stuffing violations and park in ERROR until sync.
//
// state | meaning
// RUN   | decode each symbol and push it, count consecutive 1s
// SKIP  | next symbol is a stuffed bit: update level only, push nothing
// ERROR | stuffing violation seen: track level only until sync (error build only)
module nrzi_destuff_decoder #(
    parameter int STUFF_LEN  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sym_in,
    input  logic i_sym_valid,
    input  logic i_sync,
    output logic o_in_ready,
    output logic o_out_bit,
    output logic o_out_valid,
    input  logic i_out_ready,
    output logic o_overflow,
    output logic o_stuff_error
);
    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STUFF_CNT = CNT_W'(STUFF_LEN);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
    localparam logic [1:0] ST_ERROR = 2'd2;
`endif

    logic [1:0]       r_state;
    logic             r_prev_level;
    logic [CNT_W-1:0] r_ones_cnt;
    logic             r_overflow;

    logic             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_sym;
    logic             w_d;
    logic [CNT_W-1:0] w_ones_inc;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;

    // sync outranks a coincident symbol, so the symbol is simply not seen
    assign w_sym      = i_sym_valid & ~i_sync;
    assign w_d        = ~(i_sym_in ^ r_prev_level);
    assign w_ones_inc = r_ones_cnt + CNT_W'(1);
    assign w_push     = w_sym & (r_state == ST_RUN);

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & i_out_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);

    assign o_in_ready  = ~w_full;
    assign o_out_valid = ~w_empty;
    assign o_out_bit   = w_empty ? 1'b0 : r_mem[r_rd_ptr];
    assign o_overflow  = r_overflow;

`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
    logic r_stuff_error;
    assign o_stuff_error = r_stuff_error;
`else
    assign o_stuff_error = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_prev_level <= 1'b1;
            r_ones_cnt   <= '0;
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
            r_stuff_error <= 1'b0;
`endif
        end else if (i_sync) begin
            r_state      <= ST_RUN;
            r_prev_level <= 1'b1;
            r_ones_cnt   <= '0;
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
            r_stuff_error <= 1'b0;
`endif
        end else begin
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
            r_stuff_error <= 1'b0;
`endif
            if (w_sym) begin
                r_prev_level <= i_sym_in;
                case (r_state)
                    ST_RUN: begin
                        if (!w_d) begin
                            r_ones_cnt <= '0;
                        end else if (w_ones_inc == STUFF_CNT) begin
                            r_ones_cnt <= '0;
                            r_state    <= ST_SKIP;
                        end else begin
                            r_ones_cnt <= w_ones_inc;
                        end
                    end
                    ST_SKIP: begin
                        r_ones_cnt <= '0;
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
                        if (w_d) begin
                            r_stuff_error <= 1'b1;
                            r_state       <= ST_ERROR;
                        end else begin
                            r_state <= ST_RUN;
                        end
`else
                        // a missing transition is tolerated and the bit dropped as a stuff bit
                        r_state <= ST_RUN;
`endif
                    end
`ifdef NRZI_DESTUFF_STUFF_ERROR_EN
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
`endif
                    default: begin
                        r_state    <= ST_RUN;
                        r_ones_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_d;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
